// File: rtl/d3s_frev_ts_scheduler_if.sv
// Handshake bundle for d3s_frev_ts_scheduler: two timestamp sources and the datapath consumer.
// slave = scheduler view, master = environment view.
interface d3s_frev_ts_scheduler_if;
  logic [31:0] src0_tai_i;
  logic [31:0] src0_nsec_i;
  logic        src0_valid_i;
  logic        src0_ready_o;
  logic [31:0] src1_tai_i;
  logic [31:0] src1_nsec_i;
  logic        src1_valid_i;
  logic        src1_ready_o;
  logic [31:0] frev_ts_tai_o;
  logic [31:0] frev_ts_nsec_o;
  logic        frev_ts_valid_o;
  logic        frev_ts_ready_i;

  modport slave (
    input  src0_tai_i, src0_nsec_i, src0_valid_i,
    output src0_ready_o,
    input  src1_tai_i, src1_nsec_i, src1_valid_i,
    output src1_ready_o,
    output frev_ts_tai_o, frev_ts_nsec_o, frev_ts_valid_o,
    input  frev_ts_ready_i
  );

  modport master (
    output src0_tai_i, src0_nsec_i, src0_valid_i,
    input  src0_ready_o,
    output src1_tai_i, src1_nsec_i, src1_valid_i,
    input  src1_ready_o,
    input  frev_ts_tai_o, frev_ts_nsec_o, frev_ts_valid_o,
    output frev_ts_ready_i
  );
endinterface

// File: rtl/d3s_frev_ts_scheduler.sv
// Round-robin Frev timestamp scheduler: normalize stage, FIFO and output holding register.
// Optional stale-entry discard is enabled by defining D3S_FREV_STALE_DROP_EN.
module d3s_frev_ts_scheduler #(
  parameter int unsigned g_fifo_depth = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  d3s_frev_ts_scheduler_if.slave bus,
  input  logic [31:0]            adjust_ns_i,
  input  logic                   tm_time_valid_i,
  input  logic [31:0]            tm_tai_i,
  input  logic [27:0]            tm_cycles_i,
  output logic [4:0]             fifo_count_o,
  output logic [15:0]            drop_cnt_o
);
  localparam int unsigned AW       = (g_fifo_depth > 2) ? $clog2(g_fifo_depth) : 1;
  localparam logic [31:0] NS_PER_S = 32'd1_000_000_000;
  localparam logic [5:0]  DEPTH6   = 6'(g_fifo_depth);

  typedef enum logic [1:0] { EMPTY, LOAD, PRESENT } out_state_e;

  out_state_e    state_q;
  logic          en_q, last_q, norm_vld_q;
  logic [31:0]   norm_tai_q, norm_nsec_q, out_tai_q, out_nsec_q;
  logic [31:0]   mem_tai_q  [g_fifo_depth];
  logic [31:0]   mem_nsec_q [g_fifo_depth];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [4:0]    cnt_q;
  logic [15:0]   drop_q;

  logic        gnt0, gnt1, space, rdy0, rdy1, xfer, in_ok, pend, present, cons, pop, stale;
  logic [31:0] sel_tai, sel_nsec, sum_ns;
  logic [5:0]  occ;

  // last_q = 1 means src1 was granted last, so src0 wins the first contention after reset.
  always_comb begin
    occ      = {1'b0, cnt_q} + {5'd0, norm_vld_q};
    space    = en_q && (occ < DEPTH6);
    gnt1     = bus.src1_valid_i && (!bus.src0_valid_i || !last_q);
    gnt0     = bus.src0_valid_i && !gnt1;
    rdy0     = space && gnt0;
    rdy1     = space && gnt1;
    xfer     = rdy0 || rdy1;
    sel_tai  = rdy1 ? bus.src1_tai_i  : bus.src0_tai_i;
    sel_nsec = rdy1 ? bus.src1_nsec_i : bus.src0_nsec_i;
    sum_ns   = sel_nsec + adjust_ns_i;
    in_ok    = sel_nsec < NS_PER_S;
    pend     = (cnt_q != 5'd0) || norm_vld_q;
    present  = state_q == PRESENT;
    cons     = present && bus.frev_ts_ready_i;
    pop      = state_q == LOAD;
  end

`ifdef D3S_FREV_STALE_DROP_EN
  always_comb begin
    stale = present && tm_time_valid_i && !bus.frev_ts_ready_i &&
            ((out_tai_q < tm_tai_i) ||
             ((out_tai_q == tm_tai_i) && (out_nsec_q[31:3] <= {1'b0, tm_cycles_i})));
  end
`else
  logic unused_tm;
  assign stale     = 1'b0;
  assign unused_tm = ^{tm_time_valid_i, tm_tai_i, tm_cycles_i};
`endif

  // An entry still in the normalize stage counts as pending so EMPTY->LOAD overlaps its FIFO write.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= EMPTY;
      en_q        <= 1'b0;
      last_q      <= 1'b1;
      norm_vld_q  <= 1'b0;
      norm_tai_q  <= '0;
      norm_nsec_q <= '0;
      out_tai_q   <= '0;
      out_nsec_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      drop_q      <= '0;
    end else begin
      en_q       <= 1'b1;
      norm_vld_q <= xfer && in_ok;
      if (xfer) begin
        last_q <= rdy1;
        if (sum_ns >= NS_PER_S) begin
          norm_nsec_q <= sum_ns - NS_PER_S;
          norm_tai_q  <= sel_tai + 32'd1;
        end else begin
          norm_nsec_q <= sum_ns;
          norm_tai_q  <= sel_tai;
        end
      end
      if (norm_vld_q) begin
        mem_tai_q[wr_ptr_q]  <= norm_tai_q;
        mem_nsec_q[wr_ptr_q] <= norm_nsec_q;
        wr_ptr_q             <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        out_tai_q  <= mem_tai_q[rd_ptr_q];
        out_nsec_q <= mem_nsec_q[rd_ptr_q];
        rd_ptr_q   <= rd_ptr_q + AW'(1);
      end
      cnt_q <= cnt_q + {4'd0, norm_vld_q} - {4'd0, pop};
      unique case (state_q)
        EMPTY:   if (pend) state_q <= LOAD;
        LOAD:    state_q <= PRESENT;
        PRESENT: if (cons || stale) state_q <= pend ? LOAD : EMPTY;
        default: state_q <= EMPTY;
      endcase
      if (stale && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
    end
  end

  assign bus.src0_ready_o    = rdy0;
  assign bus.src1_ready_o    = rdy1;
  assign bus.frev_ts_valid_o = present;
  assign bus.frev_ts_tai_o   = out_tai_q;
  assign bus.frev_ts_nsec_o  = out_nsec_q;
  assign fifo_count_o        = cnt_q + {4'd0, present};
  assign drop_cnt_o          = drop_q;
endmodule

// File: doc/d3s_frev_ts_scheduler.md
D3S_FREV_TS_SCHEDULER -- requirements
Module: d3s_frev_ts_scheduler

Interface
REQ-001 SHALL have parameter g_fifo_depth, default 4, timestamp FIFO depth; must be a power of two, 2..16.
REQ-002 SHALL have port clk_i  in  1  single clock for all logic (clk_wr_ref domain).
REQ-003 SHALL have port rst_n_i  in  1  reset; synchronous, active-low.
REQ-004 SHALL have ports src0_tai_i / src0_nsec_i / src0_valid_i  in  32/32/1  requester 0 (WR Frev timestamp source).
REQ-005 SHALL have port src0_ready_o  out  1  requester 0 accept.
REQ-006 SHALL have ports src1_tai_i / src1_nsec_i / src1_valid_i  in  32/32/1  requester 1 (host-injected timestamp).
REQ-007 SHALL have port src1_ready_o  out  1  requester 1 accept.
REQ-008 SHALL have port adjust_ns_i  in  32  nanosecond offset added to every timestamp, below 1e9.
REQ-009 SHALL have ports tm_time_valid_i / tm_tai_i / tm_cycles_i  in  1/32/28  WR time; cycles count 8 ns.
REQ-010 SHALL have ports frev_ts_tai_o / frev_ts_nsec_o / frev_ts_valid_o  out  32/32/1  timestamp offered to the upsample/divide datapath.
REQ-011 SHALL have port frev_ts_ready_i  in  1  datapath accept (its frev_ts_ready).
REQ-012 SHALL have port fifo_count_o  out  5  entries held, output register included.
REQ-013 SHALL have port drop_cnt_o  out  16  stale timestamps discarded, saturating.

Function
REQ-014 SHALL complete a source transfer when srcN_valid_i and srcN_ready_o are both 1 on a clock edge; at most one transfer per cycle in total.
REQ-015 SHALL arbitrate round-robin: when both valid, grant the source not granted last; after reset, src0 has priority.
REQ-016 SHALL drive srcN_ready_o = 1 only when N is granted and FIFO occupancy plus the in-flight normalize entry is below g_fifo_depth.
REQ-017 SHALL register accepted timestamps in a normalize stage: ns = nsec + adjust_ns_i; if ns >= 1e9 then nsec = ns - 1e9 and tai = tai + 1, else unchanged.
REQ-018 SHALL reject, without storing, a source timestamp with nsec_i >= 1e9. The source handshake still completes. This is not counted in drop_cnt_o.
REQ-019 SHALL write the normalize stage to the FIFO on the next cycle; latency from source transfer to frev_ts_valid_o with empty FIFO = 2 cycles.
REQ-020 SHALL keep the output holding register in one of states EMPTY, LOAD and PRESENT:
- EMPTY -> LOAD when the FIFO is non-empty.
- LOAD -> PRESENT after one cycle, with the head registered.
- PRESENT -> LOAD on a consumer transfer when the FIFO is non-empty, otherwise -> EMPTY.
REQ-021 SHALL assert frev_ts_valid_o only in PRESENT; tai/nsec outputs SHALL remain stable while valid and not ready.
REQ-022 SHALL complete a consumer transfer when frev_ts_valid_o and frev_ts_ready_i are both 1.
REQ-023 SHALL handle simultaneous FIFO write and read correctly, including full-to-full and empty pass-through.
REQ-024 SHALL treat FIFO pointers as wrapping modulo g_fifo_depth; the count SHALL never exceed g_fifo_depth and never underflow.

Reset
REQ-025 SHALL, on rst_n_i = 0 at a clock edge:
- clear FIFO, normalize stage and arbiter priority (src0);
- enter EMPTY;
- drive frev_ts_valid_o = 0, src0_ready_o = src1_ready_o = 0, fifo_count_o = 0, drop_cnt_o = 0, frev_ts_tai_o = frev_ts_nsec_o = 0.
REQ-026 SHALL discard in-flight entries on reset asserted mid-operation; ready outputs SHALL rise no earlier than the first cycle after rst_n_i returns to 1.

Configuration
REQ-027 SHALL implement stale-drop logic when macro D3S_FREV_STALE_DROP_EN is defined:
- In PRESENT, with tm_time_valid_i = 1 and no consumer transfer that cycle, the entry is stale when tai < tm_tai_i, or when tai == tm_tai_i and nsec[31:3] <= tm_cycles_i.
- A stale entry SHALL be discarded as if consumed, and drop_cnt_o SHALL increment, saturating at 0xFFFF.
REQ-028 SHALL, without D3S_FREV_STALE_DROP_EN, never discard entries and tie drop_cnt_o to 0.

Verification
REQ-029 SHALL verify wrap: src0 tai 10, nsec 999_998_000, adjust 5000 -> output tai 11, nsec 3000, valid 2 cycles after transfer.
REQ-030 SHALL verify arbitration: both sources valid continuously, consumer ready = 1 -> grants alternate src0, src1, src0, ...; no timestamp lost or duplicated.
REQ-031 SHALL verify full: depth 4, ready_i = 0, src0 sends 6 -> 5 accepted (4 FIFO + output), src0_ready_o low; fifo_count_o = 5; release ready -> 5 outputs in order.
REQ-032 SHALL verify invalid input: src1 nsec 1_000_000_000 -> handshake completes, no output, drop_cnt_o unchanged.
REQ-033 SHALL verify stale drop (macro on): head tai 5, nsec 800, tm_tai 5, tm_cycles 100, ready_i = 0 -> entry discarded next cycle, drop_cnt_o = 1; macro off -> held, drop_cnt_o = 0.
REQ-034 SHALL verify reset: assert rst_n_i with 3 entries queued -> next cycle valid_o = 0, fifo_count_o = 0, drop_cnt_o = 0.
